term_writer: RTL

//  Terminal sequencer for the character VRAM write port. It accepts bytes from the PS/2 receiver and

---
 rtl/term_writer_pkg.sv | 26 ++
 rtl/term_writer_fill.sv | 63 ++++++
 rtl/term_writer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/term_writer_pkg.sv
// Shared definitions for the terminal writer: state encoding, control
// characters and field widths.
package term_writer_pkg;

    localparam int ROW_W = 5;
    localparam int COL_W = 7;

    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_TAB   = 8'h09;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_BLANK = 8'h20;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_PUT   = 2'd2,
        ST_CLEAR = 2'd3
    } term_state_e;

    // Bytes that are written to the screen as-is.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/term_writer_fill.sv
// Run-length VRAM writer: writes one character to a rectangle of cells
// (rows row_first..row_last, cols col_first..col_last, row-major), one cell
// per granted cycle. Address and data are registered and hold while the
// grant is low. done pulses in the cycle the last cell is written.
module term_writer_fill
    import term_writer_pkg::*;
(
    input  logic             clk,
    input  logic             reset_low,
    input  logic             start,
    input  logic [ROW_W-1:0] row_first,
    input  logic [ROW_W-1:0] row_last,
    input  logic [COL_W-1:0] col_first,
    input  logic [COL_W-1:0] col_last,
    input  logic [7:0]       chr_in,
    input  logic             grant,
    output logic             pend,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [7:0]       chr,
    output logic             done
);

    logic [ROW_W-1:0] row_last_q;
    logic [COL_W-1:0] col_first_q;
    logic [COL_W-1:0] col_last_q;
    logic             last_cell;

    assign last_cell = (row == row_last_q) && (col == col_last_q);
    assign done      = pend && grant && last_cell;

    // Walk the rectangle; a new start overrides the final cell of the old run.
    always_ff @(posedge clk or negedge reset_low) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_low) begin
            pend        <= 1'b0;
            row         <= '0;
            col         <= '0;
            chr         <= '0;
            row_last_q  <= '0;
            col_first_q <= '0;
            col_last_q  <= '0;
        end else if (start) begin
            pend        <= 1'b1;
            row         <= row_first;
            col         <= col_first;
            chr         <= chr_in;
            row_last_q  <= row_last;
            col_first_q <= col_first;
            col_last_q  <= col_last;
        end else if (pend && grant) begin
            if (last_cell) begin
                pend <= 1'b0;
            end else if (col == col_last_q) begin
                col <= col_first_q;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/term_writer.sv
// Terminal sequencer for the character VRAM write port. Clears VRAM after
// reset, then writes printable bytes at the cursor and interprets CR, LF
// and BS; scrolling moves top_row through the VRAM ring and clears each
// new line. Optional feature macro: TERM_TAB_EN (TAB advances to the next
// multiple of 8, blanking the skipped cells).
module term_writer
    import term_writer_pkg::*;
#(
    parameter int         COLS        = 100,
    parameter int         VRAM_ROWS   = 32,
    parameter int         SCREEN_ROWS = 30,
    parameter logic [7:0] BLANK       = CHR_BLANK
) (
    input  logic             clk,
    input  logic             reset_low,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             vram_read_ce,
    output logic             vram_write_ce,
    output logic [ROW_W-1:0] vram_write_row,
    output logic [COL_W-1:0] vram_write_col,
    output logic [7:0]       vram_write_char,
    output logic [ROW_W-1:0] top_row,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col,
    output logic             busy
);

    localparam logic [ROW_W-1:0] ROW_MASK = ROW_W'(VRAM_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    term_state_e      state, state_d;
    logic             in_ready_d;
    logic [ROW_W-1:0] cur_row_d, top_row_d;
    logic [COL_W-1:0] cur_col_d;
    logic             nl_after, nl_after_d;

    logic             fill_start, fill_pend, fill_done;
    logic [ROW_W-1:0] fill_row_first, fill_row_last;
    logic [COL_W-1:0] fill_col_first, fill_col_last;
    logic [7:0]       fill_chr;

    // Cursor and viewport after a newline.
    logic [ROW_W-1:0] nl_row, nl_top;
    assign nl_row = (cursor_row + ROW_W'(1)) & ROW_MASK;
    assign nl_top = (nl_row == ((top_row + ROW_W'(SCREEN_ROWS)) & ROW_MASK))
                  ? ((top_row + ROW_W'(1)) & ROW_MASK) : top_row;

`ifdef TERM_TAB_EN
    logic [COL_W:0] tab_stop;
    assign tab_stop = {1'b0, cursor_col | COL_W'(7)} + (COL_W + 1)'(1);
`endif

    assign vram_write_ce = fill_pend & ~vram_read_ce;
    assign busy          = (state != ST_IDLE);

    term_writer_fill u_fill (
        .clk       (clk),
        .reset_low (reset_low),
        .start     (fill_start),
        .row_first (fill_row_first),
        .row_last  (fill_row_last),
        .col_first (fill_col_first),
        .col_last  (fill_col_last),
        .chr_in    (fill_chr),
        .grant     (~vram_read_ce),
        .pend      (fill_pend),
        .row       (vram_write_row),
        .col       (vram_write_col),
        .chr       (vram_write_char),
        .done      (fill_done)
    );

    // State, handshake, cursor and viewport registers.
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state      <= ST_INIT;
            in_ready   <= 1'b0;
            cursor_row <= '0;
            cursor_col <= '0;
            top_row    <= '0;
            nl_after   <= 1'b0;
        end else begin
            state      <= state_d;
            in_ready   <= in_ready_d;
            cursor_row <= cur_row_d;
            cursor_col <= cur_col_d;
            top_row    <= top_row_d;
            nl_after   <= nl_after_d;
        end
    end

    // Next-state, byte decode and fill-run requests.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d        = state;
        cur_row_d      = cursor_row;
        cur_col_d      = cursor_col;
        top_row_d      = top_row;
        nl_after_d     = nl_after;
        fill_start     = 1'b0;
        fill_row_first = cursor_row;
        fill_row_last  = cursor_row;
        fill_col_first = cursor_col;
        fill_col_last  = cursor_col;
        fill_chr       = BLANK;

        case (state)
            ST_INIT: begin
                fill_row_first = '0;
                fill_row_last  = ROW_MASK;
                fill_col_first = '0;
                fill_col_last  = COL_LAST;
                if (!fill_pend)     fill_start = 1'b1;
                else if (fill_done) state_d    = ST_IDLE;
            end
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    if (is_printable(in_data)) begin
                        fill_start = 1'b1;
                        fill_chr   = in_data;
                        state_d    = ST_PUT;
                        if (cursor_col == COL_LAST) begin
                            cur_row_d  = nl_row;
                            cur_col_d  = '0;
                            top_row_d  = nl_top;
                            nl_after_d = 1'b1;
                        end else begin
                            cur_col_d  = cursor_col + COL_W'(1);
                            nl_after_d = 1'b0;
                        end
                    end else begin
                        case (in_data)
                            CHR_CR: cur_col_d = '0;
                            CHR_LF: begin
                                cur_row_d      = nl_row;
                                cur_col_d      = '0;
                                top_row_d      = nl_top;
                                fill_start     = 1'b1;
                                fill_row_first = nl_row;
                                fill_row_last  = nl_row;
                                fill_col_first = '0;
                                fill_col_last  = COL_LAST;
                                state_d        = ST_CLEAR;
                            end
                            CHR_BS: begin
                                if (cursor_col != '0) begin
                                    cur_col_d      = cursor_col - COL_W'(1);
                                    fill_start     = 1'b1;
                                    fill_col_first = cursor_col - COL_W'(1);
                                    fill_col_last  = cursor_col - COL_W'(1);
                                    nl_after_d     = 1'b0;
                                    state_d        = ST_PUT;
                                end
                            end
`ifdef TERM_TAB_EN
                            CHR_TAB: begin
                                fill_start = 1'b1;
                                state_d    = ST_PUT;
                                if (tab_stop >= (COL_W + 1)'(COLS)) begin
                                    fill_col_last = COL_LAST;
                                    cur_row_d     = nl_row;
                                    cur_col_d     = '0;
                                    top_row_d     = nl_top;
                                    nl_after_d    = 1'b1;
                                end else begin
                                    fill_col_last = COL_W'(tab_stop - (COL_W + 1)'(1));
                                    cur_col_d     = COL_W'(tab_stop);
                                    nl_after_d    = 1'b0;
                                end
                            end
`else
                            CHR_TAB: ;  // dropped like other control bytes
`endif
                            default: ;
                        endcase
                    end
                end
            end
            ST_PUT: begin
                if (fill_done) begin
                    if (nl_after) begin
                        // Cursor already sits on the new line; clear it next.
                        fill_start     = 1'b1;
                        fill_col_first = '0;
                        fill_col_last  = COL_LAST;
                        state_d        = ST_CLEAR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CLEAR: begin
                if (fill_done) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

endmodule
